pc_fetch_unit: RTL and testbench

//  Owns the program counter and drives the instruction-memory request interface.

---
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter owner and instruction fetch front end. One
//               outstanding imem request, branch-unit redirects, and
//               valid/ready delivery of fetched instructions to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic        jump,
    input  logic [31:0] offset,
    input  logic [31:0] br_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready,
    output logic        misalign
);

    localparam logic [1:0] c_S_REQ  = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_OUT  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_discard;
    logic        w_discard_nxt;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_misalign;
    logic        w_capture;
    logic        w_kill;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_redirect;

    assign w_target   = br_pc + offset;
    assign w_taken    = br_valid & jump;
    // A taken target that is only halfword aligned is reported, never followed.
    assign w_redirect = w_taken & ~w_target[1];

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_discard_nxt = r_discard;
        w_capture     = 1'b0;
        w_kill        = 1'b0;
        case (r_state)
            c_S_REQ: begin
                if (imem_ready) begin
                    w_state_nxt = c_S_WAIT;
                    // The old address was accepted, so its response must be dropped.
                    if (w_redirect) begin
                        w_pc_nxt      = w_target;
                        w_discard_nxt = 1'b1;
                    end
                end else if (w_redirect) begin
                    w_pc_nxt = w_target;
                end
            end
            c_S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = c_S_REQ;
                    if (r_discard | w_redirect) begin
                        w_discard_nxt = 1'b0;
                        if (w_redirect) begin
                            w_pc_nxt = w_target;
                        end
                    end else begin
                        w_capture   = 1'b1;
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = c_S_OUT;
                    end
                end else if (w_redirect) begin
                    w_pc_nxt      = w_target;
                    w_discard_nxt = 1'b1;
                end
            end
            c_S_OUT: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_kill      = 1'b1;
                    w_state_nxt = c_S_REQ;
                end else if (id_ready) begin
                    w_kill      = 1'b1;
                    w_state_nxt = c_S_REQ;
                end
            end
            default: begin
                w_state_nxt = c_S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_S_REQ;
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_instr <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_discard  <= w_discard_nxt;
            r_misalign <= w_taken & w_target[1];
            if (w_capture) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_instr <= imem_rdata;
            end else if (w_kill) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    // Request is suppressed while reset is held even though the state is S_REQ.
    assign imem_req  = rst_n & (r_state == c_S_REQ);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed, table-driven bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        jump;
    logic [31:0] offset;
    logic [31:0] br_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        misalign;

    int n_chk;
    int n_err;

    pc_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_valid    (br_valid),
        .jump        (jump),
        .offset      (offset),
        .br_pc       (br_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .id_ready    (id_ready),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        brv;
        logic        jmp;
        logic [31:0] bpc;
        logic [31:0] off;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        idr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic brv, input logic jmp, input logic [31:0] bpc,
                                input logic [31:0] off, input logic rdy, input logic rv,
                                input logic [31:0] rdata, input logic idr, input logic e_req,
                                input logic [31:0] e_addr, input logic e_v, input logic [31:0] e_pc,
                                input logic [31:0] e_ins, input logic e_mis);
        vec_t v;
        v.brv = brv; v.jmp = jmp; v.bpc = bpc; v.off = off;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
        v.e_pc = e_pc; v.e_ins = e_ins; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        br_valid = 1'b0; jump = 1'b0; offset = 32'd0; br_pc = 32'd0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req"},      {31'd0, imem_req}, 32'd0);
        chk({tag, " if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, " if_pc"},    if_pc,             32'd0);
        chk({tag, " if_instr"}, if_instr,          32'd0);
        chk({tag, " misalign"}, {31'd0, misalign}, 32'd0);
    endtask

    localparam logic [31:0] c_I0 = 32'h1111_0013;
    localparam logic [31:0] c_I1 = 32'h2222_0013;
    localparam logic [31:0] c_I2 = 32'h3333_0013;
    localparam logic [31:0] c_I3 = 32'h4444_0013;
    localparam logic [31:0] c_I4 = 32'h5555_0013;
    localparam logic [31:0] c_I5 = 32'h6666_0013;
    localparam logic [31:0] c_JK = 32'hDEAD_BEEF;

    initial begin
        n_chk = 0;
        n_err = 0;
        drive_idle();
        rst_n = 1'b1;

        // brv jmp br_pc off | rdy rv rdata idr | req addr v if_pc instr mis
        vecs.push_back(mk(0,0,0,0,                 1,0,0,0,     1,32'h100,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_I0,0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,1,     0,0,1,32'h100,c_I0,0));
        vecs.push_back(mk(0,0,0,0,                 1,0,0,0,     1,32'h104,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_I1,0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,1,     0,0,1,32'h104,c_I1,0));
        vecs.push_back(mk(0,0,0,0,                 1,0,0,0,     1,32'h108,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_I2,0,  0,0,0,0,0,0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,0,0,0,             0,0,0,0,     0,0,1,32'h108,c_I2,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,1,     0,0,1,32'h108,c_I2,0));
        // redirect while waiting: pending response dropped, next fetch at 0x1F8
        vecs.push_back(mk(0,0,0,0,                 1,0,0,0,     1,32'h10C,0,0,0,0));
        vecs.push_back(mk(1,1,32'h200,32'hFFFF_FFF8, 0,0,0,0,   0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_JK,0,  0,0,0,0,0,0));
        // redirect coincident with acceptance
        vecs.push_back(mk(1,1,32'h30,32'h10,       1,0,0,0,     1,32'h1F8,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_JK,0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 1,0,0,0,     1,32'h40,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_I3,0,  0,0,0,0,0,0));
        // misaligned taken target in S_OUT with id_ready
        vecs.push_back(mk(1,1,32'h100,32'h6,       0,0,0,1,     0,0,1,32'h40,c_I3,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,     1,32'h44,0,0,0,1));
        // misaligned but not taken: no pulse
        vecs.push_back(mk(1,0,32'h100,32'h6,       1,0,0,0,     1,32'h44,0,0,0,0));
        // two redirects while draining: last wins
        vecs.push_back(mk(1,1,32'h80,32'h0,        0,0,0,0,     0,0,0,0,0,0));
        vecs.push_back(mk(1,1,32'h80,32'h20,       0,0,0,0,     0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_JK,0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 1,0,0,0,     1,32'hA0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_I4,0,  0,0,0,0,0,0));
        // redirect kills instruction in S_OUT without id_ready
        vecs.push_back(mk(1,1,32'h0,32'hC,         0,0,0,0,     0,0,1,32'hA0,c_I4,0));
        // wrapping target accepted with the request
        vecs.push_back(mk(1,1,32'hFFFF_FFFC,32'h8, 1,0,0,0,     1,32'hC,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,1,c_JK,0,  0,0,0,0,0,0));
        // redirect while request not yet accepted
        vecs.push_back(mk(1,1,32'h10,32'h10,       0,0,0,0,     1,32'h4,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,                 0,0,0,0,     1,32'h20,0,0,0,0));

        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 chk_reset_vals("init_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            br_valid = vecs[i].brv; jump = vecs[i].jmp;
            br_pc = vecs[i].bpc; offset = vecs[i].off;
            imem_ready = vecs[i].rdy; imem_rvalid = vecs[i].rv;
            imem_rdata = vecs[i].rdata; id_ready = vecs[i].idr;
            #1;
            chk($sformatf("v%0d req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d misalign", i), {31'd0, misalign}, {31'd0, vecs[i].e_mis});
            if (vecs[i].e_req)
                chk($sformatf("v%0d addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].e_v) begin
                chk($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
                chk($sformatf("v%0d if_instr", i), if_instr, vecs[i].e_ins);
            end
        end

        // reset during S_WAIT, stale response arrives after release
        @(negedge clk);
        drive_idle();
        imem_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        #1 chk("rst_seq wait req", {31'd0, imem_req}, 32'd0);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("mid_reset");
        @(negedge clk);
        #1 chk_reset_vals("mid_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = c_JK;
        #1;
        chk("post_rst req", {31'd0, imem_req}, 32'd1);
        chk("post_rst addr", imem_addr, 32'h100);
        @(negedge clk);
        drive_idle();
        #1;
        chk("stale ignored req", {31'd0, imem_req}, 32'd1);
        chk("stale ignored addr", imem_addr, 32'h100);
        chk("stale ignored valid", {31'd0, if_valid}, 32'd0);
        imem_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        imem_rvalid = 1'b1;
        imem_rdata = c_I5;
        @(negedge clk);
        drive_idle();
        id_ready = 1'b1;
        #1;
        chk("post_rst if_valid", {31'd0, if_valid}, 32'd1);
        chk("post_rst if_pc", if_pc, 32'h100);
        chk("post_rst if_instr", if_instr, c_I5);
        @(negedge clk);
        drive_idle();
        #1 chk("post_rst next addr", imem_addr, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
